// File: rtl/fxp_alu_seq.sv
// fxp_alu_seq: handshaked signed fixed-point ALU (Qm.Q, N-bit words).
// add/sub/mul finish in one cycle; div uses a restoring divider that
// produces one quotient bit per cycle over N+Q cycles.
// Build option: FXP_ALU_SAT_EN defined -> overflowed results saturate to
// MAX/MIN; undefined -> overflowed results wrap.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operation
// DIV   | restoring divider iterating, one quotient bit per cycle
// DONE  | result presented on out, held until out_ready
module fxp_alu_seq #(
    parameter int N = 32,
    parameter int Q = 20
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [1:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out,
    output logic         overflow,
    output logic         div_by_zero
);

    localparam int DW = N + Q;
    localparam int CW = $clog2(DW);

    localparam logic [N-1:0]  MAX_V       = {1'b0, {(N-1){1'b1}}};
    localparam logic [N-1:0]  MIN_V       = {1'b1, {(N-1){1'b0}}};
    // quotient magnitude limits: MAX for a positive result, |MIN| for a negative one
    localparam logic [DW-1:0] DIV_POS_LIM = {{(Q+1){1'b0}}, {(N-1){1'b1}}};
    localparam logic [DW-1:0] DIV_NEG_LIM = {{Q{1'b0}}, 1'b1, {(N-1){1'b0}}};

`ifdef FXP_ALU_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   out_q, out_d;
    logic           ovf_q, ovf_d;
    logic           dbz_q, dbz_d;
    logic [DW-1:0]  quo_q, quo_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   dvsr_q, dvsr_d;
    logic           neg_q, neg_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [N-1:0]     sum, diff;
    logic             add_ovf, sub_ovf;
    logic [2*N-1:0]   a_ext, b_ext;
    logic [2*N-Q-1:0] mul_hi;
    logic             mul_ovf;
    logic [N-1:0]     a_mag, b_mag;
    logic [N:0]       trial, trial_sub;
    logic             q_bit;
    logic [N-1:0]     rem_nxt;
    logic [DW-1:0]    quo_nxt;
    logic [N-1:0]     div_wrap;
    logic             div_ovf;

    // Single-cycle arithmetic on the live operands plus one divider step.
    always_comb begin
        sum     = a + b;
        diff    = a - b;
        add_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
        sub_ovf = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);

        // product bits below Q are dropped; upper slice must be pure sign extension
        a_ext   = {{N{a[N-1]}}, a};
        b_ext   = {{N{b[N-1]}}, b};
        mul_hi  = (2*N-Q)'((a_ext * b_ext) >> Q);
        mul_ovf = !((&mul_hi[2*N-Q-1:N-1]) || !(|mul_hi[2*N-Q-1:N-1]));

        a_mag   = a[N-1] ? -a : a;
        b_mag   = b[N-1] ? -b : b;

        trial     = {rem_q, quo_q[DW-1]};
        trial_sub = trial - {1'b0, dvsr_q};
        q_bit     = ~trial_sub[N];
        rem_nxt   = q_bit ? trial_sub[N-1:0] : trial[N-1:0];
        quo_nxt   = {quo_q[DW-2:0], q_bit};

        div_wrap  = neg_q ? -quo_nxt[N-1:0] : quo_nxt[N-1:0];
        div_ovf   = neg_q ? (quo_nxt > DIV_NEG_LIM) : (quo_nxt > DIV_POS_LIM);
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        ovf_d   = ovf_q;
        dbz_d   = dbz_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        neg_d   = neg_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dbz_d = 1'b0;
                    if (op == OP_ADD) begin
                        ovf_d   = add_ovf;
                        out_d   = (SAT_EN && add_ovf) ? (a[N-1] ? MIN_V : MAX_V) : sum;
                        state_d = S_DONE;
                    end else if (op == OP_SUB) begin
                        ovf_d   = sub_ovf;
                        out_d   = (SAT_EN && sub_ovf) ? (a[N-1] ? MIN_V : MAX_V) : diff;
                        state_d = S_DONE;
                    end else if (op == OP_MUL) begin
                        ovf_d   = mul_ovf;
                        out_d   = (SAT_EN && mul_ovf) ? (mul_hi[2*N-Q-1] ? MIN_V : MAX_V)
                                                      : mul_hi[N-1:0];
                        state_d = S_DONE;
                    end else if (b == '0) begin
                        dbz_d   = 1'b1;
                        ovf_d   = 1'b1;
                        out_d   = SAT_EN ? (a[N-1] ? MIN_V : MAX_V) : '0;
                        state_d = S_DONE;
                    end else begin
                        quo_d   = {a_mag, {Q{1'b0}}};
                        rem_d   = '0;
                        dvsr_d  = b_mag;
                        neg_d   = a[N-1] ^ b[N-1];
                        cnt_d   = CW'(DW - 1);
                        state_d = S_DIV;
                    end
                end
            end
            S_DIV: begin
                quo_d = quo_nxt;
                rem_d = rem_nxt;
                if (cnt_q == '0) begin
                    // last quotient bit lands this cycle; finalise sign and range
                    ovf_d   = div_ovf;
                    dbz_d   = 1'b0;
                    out_d   = (SAT_EN && div_ovf) ? (neg_q ? MIN_V : MAX_V) : div_wrap;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            dbz_q   <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvsr_q  <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            dbz_q   <= dbz_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out         = out_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_q;

endmodule
